regfile_write_arbiter: RTL and testbench

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter.sv | 130 +++++++++++++
 tb/tb_regfile_write_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Two-requester register-file write arbiter.
// Each requester (ALU writeback, load writeback) owns a one-entry holding slot.
// One slot is granted per cycle, round-robin on contention, and the granted
// write is presented on the registered WE3/A3/WD3 port one cycle later.
// pending_mask flags every register whose write has not yet been committed.
module regfile_write_arbiter #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                         CLK,
  input  logic                         reset,
  input  logic                         req0_valid,
  input  logic [ADDR_WIDTH-1:0]        req0_addr,
  input  logic [DATA_WIDTH-1:0]        req0_data,
  output logic                         req0_ready,
  input  logic                         req1_valid,
  input  logic [ADDR_WIDTH-1:0]        req1_addr,
  input  logic [DATA_WIDTH-1:0]        req1_data,
  output logic                         req1_ready,
  output logic                         WE3,
  output logic [ADDR_WIDTH-1:0]        A3,
  output logic [DATA_WIDTH-1:0]        WD3,
  output logic [(2**ADDR_WIDTH)-1:0]   pending_mask
);

  localparam int unsigned NREG = 2**ADDR_WIDTH;
  localparam logic [NREG-1:0] BIT0 = {{(NREG-1){1'b0}}, 1'b1};

  // Holding slots and round-robin pointer (0 = requester 0 wins next tie)
  logic                  r_hold_valid0;
  logic [ADDR_WIDTH-1:0] r_hold_addr0;
  logic [DATA_WIDTH-1:0] r_hold_data0;
  logic                  r_hold_valid1;
  logic [ADDR_WIDTH-1:0] r_hold_addr1;
  logic [DATA_WIDTH-1:0] r_hold_data1;
  logic                  r_prio;

  logic                  w_grant0;
  logic                  w_grant1;
  logic                  w_hs0;
  logic                  w_hs1;
  logic [NREG-1:0]       w_mask;

  // Grant: a sole valid slot wins; on a tie the priority pointer decides
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (r_hold_valid0 && r_hold_valid1) begin
      w_grant0 = !r_prio;
      w_grant1 = r_prio;
    end else begin
      w_grant0 = r_hold_valid0;
      w_grant1 = r_hold_valid1;
    end
  end

  // A slot accepts a new write when empty or when it drains on this edge
  assign req0_ready = !reset && (!r_hold_valid0 || w_grant0);
  assign req1_ready = !reset && (!r_hold_valid1 || w_grant1);
  assign w_hs0      = req0_valid && req0_ready;
  assign w_hs1      = req1_valid && req1_ready;

  // Slot fill/drain; writes to x0 complete the handshake but are dropped
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_hold_valid0 <= 1'b0;
      r_hold_addr0  <= '0;
      r_hold_data0  <= '0;
      r_hold_valid1 <= 1'b0;
      r_hold_addr1  <= '0;
      r_hold_data1  <= '0;
    end else begin
      if (w_hs0) begin
        r_hold_valid0 <= (req0_addr != '0);
        r_hold_addr0  <= req0_addr;
        r_hold_data0  <= req0_data;
      end else if (w_grant0) begin
        r_hold_valid0 <= 1'b0;
      end
      if (w_hs1) begin
        r_hold_valid1 <= (req1_addr != '0);
        r_hold_addr1  <= req1_addr;
        r_hold_data1  <= req1_data;
      end else if (w_grant1) begin
        r_hold_valid1 <= 1'b0;
      end
    end
  end

  // Round-robin pointer moves to the loser after every grant
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_prio <= 1'b0;
    end else if (w_grant0) begin
      r_prio <= 1'b1;
    end else if (w_grant1) begin
      r_prio <= 1'b0;
    end
  end

  // Register-file write port; address/data hold their value when idle
  always_ff @(posedge CLK) begin
    if (reset) begin
      WE3 <= 1'b0;
      A3  <= '0;
      WD3 <= '0;
    end else begin
      WE3 <= w_grant0 || w_grant1;
      if (w_grant0) begin
        A3  <= r_hold_addr0;
        WD3 <= r_hold_data0;
      end else if (w_grant1) begin
        A3  <= r_hold_addr1;
        WD3 <= r_hold_data1;
      end
    end
  end

  // Outstanding-write scoreboard: both slots plus the write on the port
  always_comb begin
    w_mask = '0;
    if (r_hold_valid0) w_mask = w_mask | (BIT0 << r_hold_addr0);
    if (r_hold_valid1) w_mask = w_mask | (BIT0 << r_hold_addr1);
    if (WE3)           w_mask = w_mask | (BIT0 << A3);
    w_mask = w_mask & ~BIT0;
  end

  assign pending_mask = w_mask;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed, table-driven bench for regfile_write_arbiter (default widths).
module tb_regfile_write_arbiter;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0;
  logic [4:0]  req0_addr = '0;
  logic [31:0] req0_data = '0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [4:0]  req1_addr = '0;
  logic [31:0] req1_data = '0;
  logic        req1_ready;
  logic        WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic [31:0] pending_mask;

  int n_cmp = 0;
  int n_err = 0;

  regfile_write_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .CLK          (CLK),
    .reset        (reset),
    .req0_valid   (req0_valid),
    .req0_addr    (req0_addr),
    .req0_data    (req0_data),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_addr    (req1_addr),
    .req1_data    (req1_data),
    .req1_ready   (req1_ready),
    .WE3          (WE3),
    .A3           (A3),
    .WD3          (WD3),
    .pending_mask (pending_mask)
  );

  always #5 CLK = ~CLK;

  // One cycle: inputs, readies seen before the edge, port state after it
  typedef struct {
    logic        rst;
    logic        v0;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        r0;
    logic        r1;
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] mask;
  } vec_t;

  function automatic vec_t mkv(input logic rst, input logic v0, input logic [4:0] a0,
                               input logic [31:0] d0, input logic v1, input logic [4:0] a1,
                               input logic [31:0] d1, input logic r0, input logic r1,
                               input logic we, input logic [4:0] a3, input logic [31:0] wd,
                               input logic [31:0] mask);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1;
    v.r0 = r0; v.r1 = r1; v.we = we; v.a3 = a3; v.wd = wd; v.mask = mask;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input int idx);
    @(negedge CLK);
    reset      = v.rst;
    req0_valid = v.v0; req0_addr = v.a0; req0_data = v.d0;
    req1_valid = v.v1; req1_addr = v.a1; req1_data = v.d1;
    #1;
    chk("req0_ready", idx, 32'(req0_ready), 32'(v.r0));
    chk("req1_ready", idx, 32'(req1_ready), 32'(v.r1));
    @(posedge CLK);
    #1;
    chk("WE3", idx, 32'(WE3), 32'(v.we));
    chk("A3", idx, 32'(A3), 32'(v.a3));
    chk("WD3", idx, 32'(WD3), v.wd);
    chk("pending_mask", idx, pending_mask, v.mask);
  endtask

  vec_t tbl[19];
  vec_t v;
  localparam logic [31:0] DA = 32'h0000_000A;
  localparam logic [31:0] DB = 32'h0000_000B;

  initial begin
    //            rst v0 a0 d0              v1 a1 d1              r0 r1 we a3 wd              mask
    // reset: attempted writes are refused
    tbl[0]  = mkv(1, 1, 9, 32'h1,           1, 9, 32'h2,          0, 0, 0, 0, 32'h0,          32'h0);
    tbl[1]  = mkv(1, 0, 0, 32'h0,           0, 0, 32'h0,          0, 0, 0, 0, 32'h0,          32'h0);
    // single write to x5
    tbl[2]  = mkv(0, 1, 5, 32'hDEADBEEF,    0, 0, 32'h0,          1, 1, 0, 0, 32'h0,          32'h20);
    tbl[3]  = mkv(0, 0, 0, 32'h0,           0, 0, 32'h0,          1, 1, 1, 5, 32'hDEADBEEF,   32'h20);
    tbl[4]  = mkv(0, 0, 0, 32'h0,           0, 0, 32'h0,          1, 1, 0, 5, 32'hDEADBEEF,   32'h0);
    // req1 single write: returns priority to requester 0
    tbl[5]  = mkv(0, 0, 0, 32'h0,           1, 2, 32'h33,         1, 1, 0, 5, 32'hDEADBEEF,   32'h4);
    tbl[6]  = mkv(0, 0, 0, 32'h0,           0, 0, 32'h0,          1, 1, 1, 2, 32'h33,         32'h4);
    // contention: x3 from r0, x4 from r1 loaded on the same edge
    tbl[7]  = mkv(0, 1, 3, 32'h11,          1, 4, 32'h22,         1, 1, 0, 2, 32'h33,         32'h18);
    tbl[8]  = mkv(0, 0, 0, 32'h0,           0, 0, 32'h0,          1, 0, 1, 3, 32'h11,         32'h18);
    tbl[9]  = mkv(0, 0, 0, 32'h0,           0, 0, 32'h0,          1, 1, 1, 4, 32'h22,         32'h10);
    tbl[10] = mkv(0, 0, 0, 32'h0,           0, 0, 32'h0,          1, 1, 0, 4, 32'h22,         32'h0);
    // x0 discard
    tbl[11] = mkv(0, 0, 0, 32'h0,           1, 0, 32'hFFFFFFFF,   1, 1, 0, 4, 32'h22,         32'h0);
    tbl[12] = mkv(0, 0, 0, 32'h0,           0, 0, 32'h0,          1, 1, 0, 4, 32'h22,         32'h0);
    // back-to-back r0 writes x1..x4
    tbl[13] = mkv(0, 1, 1, 32'h101,         0, 0, 32'h0,          1, 1, 0, 4, 32'h22,         32'h2);
    tbl[14] = mkv(0, 1, 2, 32'h102,         0, 0, 32'h0,          1, 1, 1, 1, 32'h101,        32'h6);
    tbl[15] = mkv(0, 1, 3, 32'h103,         0, 0, 32'h0,          1, 1, 1, 2, 32'h102,        32'hC);
    tbl[16] = mkv(0, 1, 4, 32'h104,         0, 0, 32'h0,          1, 1, 1, 3, 32'h103,        32'h18);
    tbl[17] = mkv(0, 0, 0, 32'h0,           0, 0, 32'h0,          1, 1, 1, 4, 32'h104,        32'h10);
    tbl[18] = mkv(0, 0, 0, 32'h0,           0, 0, 32'h0,          1, 1, 0, 4, 32'h104,        32'h0);

    for (int i = 0; i < 19; i++) step(tbl[i], i);

    // Same-address fairness on x7: first put priority back on requester 0
    step(mkv(0, 0, 0, 32'h0, 1, 6, 32'h66, 1, 1, 0, 4, 32'h104, 32'h40), 100);
    step(mkv(0, 0, 0, 32'h0, 0, 0, 32'h0,  1, 1, 1, 6, 32'h66,  32'h40), 101);
    step(mkv(0, 1, 7, DA,    1, 7, DB,     1, 1, 0, 6, 32'h66,  32'h80), 102);
    for (int k = 1; k <= 8; k++) begin
      v = mkv(0, 1, 7, DA, 1, 7, DB, logic'(k % 2 == 1), logic'(k % 2 == 0),
              1, 7, (k % 2 == 1) ? DA : DB, 32'h80);
      step(v, 102 + k);
    end
    // drain: both slots still full, requester 0 goes first
    step(mkv(0, 0, 0, 32'h0, 0, 0, 32'h0, 1, 0, 1, 7, DA, 32'h80), 111);
    step(mkv(0, 0, 0, 32'h0, 0, 0, 32'h0, 1, 1, 1, 7, DB, 32'h80), 112);
    step(mkv(0, 0, 0, 32'h0, 0, 0, 32'h0, 1, 1, 0, 7, DB, 32'h0),  113);

    // Reset mid-operation: move priority to requester 1 first
    step(mkv(0, 1, 9, 32'h99, 0, 0, 32'h0, 1, 1, 0, 7, DB,     32'h200), 200);
    step(mkv(0, 0, 0, 32'h0,  0, 0, 32'h0, 1, 1, 1, 9, 32'h99, 32'h200), 201);
    step(mkv(0, 1, 3, 32'h11, 1, 4, 32'h22, 1, 1, 0, 9, 32'h99, 32'h18), 202);
    step(mkv(1, 1, 10, 32'hA0, 1, 11, 32'hB0, 0, 0, 0, 0, 32'h0, 32'h0), 203);
    step(mkv(1, 1, 10, 32'hA0, 1, 11, 32'hB0, 0, 0, 0, 0, 32'h0, 32'h0), 204);
    step(mkv(0, 1, 3, 32'h11, 1, 4, 32'h22, 1, 1, 0, 0, 32'h0,  32'h18), 205);
    // priority is back on requester 0 after reset
    step(mkv(0, 0, 0, 32'h0,  0, 0, 32'h0, 1, 0, 1, 3, 32'h11, 32'h18), 206);
    step(mkv(0, 0, 0, 32'h0,  0, 0, 32'h0, 1, 1, 1, 4, 32'h22, 32'h10), 207);
    step(mkv(0, 0, 0, 32'h0,  0, 0, 32'h0, 1, 1, 0, 4, 32'h22, 32'h0),  208);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
